// File: rtl/n64_pkg.sv
`timescale 1ns/1ps
// Shared constants, state encodings and the per-side drive helper for the N64 remote.
package n64_pkg;

   localparam logic [7:0] POLL_CMD = 8'h01;

   localparam int T_SHORT  = 1;
   localparam int T_LONG   = 3;
   localparam int T_BIT    = 4;
   localparam int T_SAMPLE = 2;

   localparam int BTN_START = 31 - 3;
   localparam int X_MSB     = 15;
   localparam int Y_MSB     = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TX,
      ST_RX,
      ST_UPDATE
   } n64_state_t;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_TX_LOW,
      PH_TX_HIGH,
      PH_RX_WAIT,
      PH_RX_SAMPLE
   } phy_state_t;

   // Returns {enable, dir}; dir is held at 0 whenever the side is disabled.
   function automatic logic [1:0] side_drive(input logic [9:0] v, input logic [9:0] dz);
      logic [9:0] mag;
      mag = v[9] ? (~v + 10'd1) : v;
      side_drive = (mag > dz) ? {1'b1, ~v[9]} : 2'b00;
   endfunction

endpackage

// File: rtl/n64_serial_phy.sv
`timescale 1ns/1ps
// Wire side of the N64 link: shapes the poll command, samples the 32-bit reply,
// and aborts when the controller goes quiet.
//  state        | meaning
//  PH_IDLE      | line released, waiting for start
//  PH_TX_LOW    | driving the low part of a command or stop bit
//  PH_TX_HIGH   | released part of a command bit
//  PH_RX_WAIT   | waiting for a falling edge (data bit or controller stop)
//  PH_RX_SAMPLE | counting to the mid-bit sample point
module n64_serial_phy
   import n64_pkg::*;
#(
   parameter int US_CYC     = 50,
   parameter int TIMEOUT_US = 200
) (
   input  logic        Clk,
   input  logic        Global_Reset,
   input  logic        i_start,
   output logic        o_tx_done,
   output logic        o_done,
   output logic        o_timeout,
   output logic [31:0] o_data,
   inout  wire         Serial_IO
);

   localparam int TO_CYC = TIMEOUT_US * US_CYC;
   localparam int TMR_W  = $clog2(TO_CYC + 1);

   localparam logic [TMR_W-1:0] C_SHORT  = TMR_W'(T_SHORT * US_CYC - 1);
   localparam logic [TMR_W-1:0] C_LONG   = TMR_W'(T_LONG * US_CYC - 1);
   localparam logic [TMR_W-1:0] C_HI1    = TMR_W'((T_BIT - T_SHORT) * US_CYC - 1);
   localparam logic [TMR_W-1:0] C_HI0    = TMR_W'((T_BIT - T_LONG) * US_CYC - 1);
   localparam logic [TMR_W-1:0] C_SAMPLE = TMR_W'(T_SAMPLE * US_CYC - 1);
   localparam logic [TMR_W-1:0] C_TO     = TMR_W'(TO_CYC - 1);

   phy_state_t       r_state, w_state_nxt;
   logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
   logic [5:0]       r_bits, w_bits_nxt;
   logic [7:0]       r_tx_sr, w_tx_sr_nxt;
   logic             r_stop, w_stop_nxt;
   logic [31:0]      r_rx_sr, w_rx_sr_nxt;
   logic             r_drive_low, w_drive_nxt;
   logic [1:0]       r_sync;
   logic             r_line_d;
   logic             w_line, w_fall;

   assign Serial_IO = r_drive_low ? 1'b0 : 1'bz;
   assign w_line    = r_sync[1];
   assign w_fall    = r_line_d & ~r_sync[1];
   assign o_data    = r_rx_sr;

   always_ff @(posedge Clk or negedge Global_Reset) begin
      if (!Global_Reset) begin
         r_state     <= PH_IDLE;
         r_tmr       <= '0;
         r_bits      <= '0;
         r_tx_sr     <= '0;
         r_stop      <= 1'b0;
         r_rx_sr     <= '0;
         r_drive_low <= 1'b0;
         r_sync      <= 2'b11;
         r_line_d    <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_tmr       <= w_tmr_nxt;
         r_bits      <= w_bits_nxt;
         r_tx_sr     <= w_tx_sr_nxt;
         r_stop      <= w_stop_nxt;
         r_rx_sr     <= w_rx_sr_nxt;
         r_drive_low <= w_drive_nxt;
         r_sync      <= {r_sync[0], Serial_IO};
         r_line_d    <= r_sync[1];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_bits_nxt  = r_bits;
      w_tx_sr_nxt = r_tx_sr;
      w_stop_nxt  = r_stop;
      w_rx_sr_nxt = r_rx_sr;
      w_drive_nxt = r_drive_low;
      o_tx_done   = 1'b0;
      o_done      = 1'b0;
      o_timeout   = 1'b0;
      case (r_state)
         PH_IDLE: begin
            if (i_start) begin
               w_drive_nxt = 1'b1;
               w_tx_sr_nxt = POLL_CMD;
               w_bits_nxt  = 6'd8;
               w_stop_nxt  = 1'b0;
               w_rx_sr_nxt = '0;
               w_tmr_nxt   = POLL_CMD[7] ? C_SHORT : C_LONG;
               w_state_nxt = PH_TX_LOW;
            end
         end
         PH_TX_LOW: begin
            if (r_tmr == '0) begin
               w_drive_nxt = 1'b0;
               if (r_stop) begin
                  o_tx_done   = 1'b1;
                  w_stop_nxt  = 1'b0;
                  w_bits_nxt  = '0;
                  w_tmr_nxt   = C_TO;
                  w_state_nxt = PH_RX_WAIT;
               end else begin
                  w_tmr_nxt   = r_tx_sr[7] ? C_HI1 : C_HI0;
                  w_state_nxt = PH_TX_HIGH;
               end
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         PH_TX_HIGH: begin
            if (r_tmr == '0) begin
               w_drive_nxt = 1'b1;
               w_state_nxt = PH_TX_LOW;
               if (r_bits == 6'd1) begin
                  w_stop_nxt = 1'b1;
                  w_tmr_nxt  = C_SHORT;
               end else begin
                  w_bits_nxt  = r_bits - 6'd1;
                  w_tx_sr_nxt = {r_tx_sr[6:0], 1'b0};
                  w_tmr_nxt   = r_tx_sr[6] ? C_SHORT : C_LONG;
               end
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         PH_RX_WAIT: begin
            if (w_fall) begin
               if (r_bits == 6'd32) begin
                  o_done      = 1'b1;
                  w_state_nxt = PH_IDLE;
               end else begin
                  w_tmr_nxt   = C_SAMPLE;
                  w_state_nxt = PH_RX_SAMPLE;
               end
            end else if (r_tmr == '0) begin
               o_timeout   = 1'b1;
               w_state_nxt = PH_IDLE;
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         PH_RX_SAMPLE: begin
            if (r_tmr == '0) begin
               w_rx_sr_nxt = {r_rx_sr[30:0], w_line};
               w_bits_nxt  = r_bits + 6'd1;
               w_tmr_nxt   = C_TO;
               w_state_nxt = PH_RX_WAIT;
            end else begin
               w_tmr_nxt = r_tmr - 1'b1;
            end
         end
         default: w_state_nxt = PH_IDLE;
      endcase
   end

endmodule

// File: rtl/n64_remote.sv
`timescale 1ns/1ps
// N64-controller differential-drive remote: periodic poll, report latch, joystick mixing.
//  state     | meaning
//  ST_IDLE   | poll interval running
//  ST_TX     | phy sending the poll command
//  ST_RX     | phy collecting the 32-bit report
//  ST_UPDATE | latch the fresh report
module n64_remote
   import n64_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int POLL_US    = 10_000,
   parameter int TIMEOUT_US = 200,
   parameter int DEADZONE   = 16
) (
   input  logic Clk,
   input  logic Global_Reset,
   input  logic Float,
   output logic Len,
   output logic Ldir,
   output logic Ren,
   output logic Rdir,
   inout  wire  Serial_IO
);

   localparam int US_CYC   = CLK_HZ / 1_000_000;
   localparam int POLL_CYC = POLL_US * US_CYC;
   localparam int PC_W     = $clog2(POLL_CYC + 1);

   localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_CYC - 1);
   localparam logic [9:0]      DZ        = 10'(DEADZONE);

   n64_state_t      r_state, w_state_nxt;
   logic [PC_W-1:0] r_poll_cnt;
   logic [31:0]     r_report;
   logic            r_len, r_ldir, r_ren, r_rdir;
   logic            w_start, w_tx_done, w_done, w_timeout;
   logic [31:0]     w_data;
   logic [9:0]      w_x, w_y, w_left, w_right;
   logic [1:0]      w_lsd, w_rsd;
   logic [3:0]      w_drive;
   logic            w_unused;

   n64_serial_phy #(
      .US_CYC    (US_CYC),
      .TIMEOUT_US(TIMEOUT_US)
   ) u_phy (
      .Clk         (Clk),
      .Global_Reset(Global_Reset),
      .i_start     (w_start),
      .o_tx_done   (w_tx_done),
      .o_done      (w_done),
      .o_timeout   (w_timeout),
      .o_data      (w_data),
      .Serial_IO   (Serial_IO)
   );

   always_ff @(posedge Clk or negedge Global_Reset) begin
      if (!Global_Reset) begin
         r_state    <= ST_IDLE;
         r_poll_cnt <= '0;
         r_report   <= '0;
         r_len      <= 1'b0;
         r_ldir     <= 1'b0;
         r_ren      <= 1'b0;
         r_rdir     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_poll_cnt <= (r_state == ST_IDLE && !w_start) ? r_poll_cnt + 1'b1 : '0;
         if (r_state == ST_UPDATE)
            r_report <= w_data;
         else if (r_state == ST_RX && w_timeout)
            r_report <= '0;
         {r_len, r_ldir, r_ren, r_rdir} <= w_drive;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_poll_cnt == POLL_LAST) begin
               w_start     = 1'b1;
               w_state_nxt = ST_TX;
            end
         end
         ST_TX:     if (w_tx_done) w_state_nxt = ST_RX;
         ST_RX: begin
            if (w_done)
               w_state_nxt = ST_UPDATE;
            else if (w_timeout)
               w_state_nxt = ST_IDLE;
         end
         ST_UPDATE: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // 10-bit sums of two sign-extended bytes cannot overflow.
   assign w_x     = {{2{r_report[X_MSB]}}, r_report[X_MSB -: 8]};
   assign w_y     = {{2{r_report[Y_MSB]}}, r_report[Y_MSB -: 8]};
   assign w_left  = w_y + w_x;
   assign w_right = w_y - w_x;
   assign w_lsd   = side_drive(w_left, DZ);
   assign w_rsd   = side_drive(w_right, DZ);
   assign w_drive = r_report[BTN_START] ? 4'b0000 : {w_lsd, w_rsd};

   assign w_unused = ^{r_report[31:29], r_report[27:16]};

   assign Len  = r_len  & ~Float;
   assign Ldir = r_ldir & ~Float;
   assign Ren  = r_ren  & ~Float;
   assign Rdir = r_rdir & ~Float;

endmodule

// File: tb/tb_n64_remote.sv
`timescale 1ns/1ps
// Bench for n64_remote: controller model on the open-drain line, scoreboard of motor outputs.
module tb_n64_remote;

   localparam int DZ = 16;

   logic Clk = 1'b0;
   logic Global_Reset = 1'b1;
   logic Float = 1'b0;
   logic r_ctl_low = 1'b0;
   wire  Len, Ldir, Ren, Rdir;
   wire  w_sio;

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] q_exp[$];

   pullup (w_sio);
   assign w_sio = r_ctl_low ? 1'b0 : 1'bz;

   always #50 Clk = ~Clk;

   n64_remote #(
      .CLK_HZ    (10_000_000),
      .POLL_US   (20),
      .TIMEOUT_US(200),
      .DEADZONE  (DZ)
   ) dut (
      .Clk         (Clk),
      .Global_Reset(Global_Reset),
      .Float       (Float),
      .Len         (Len),
      .Ldir        (Ldir),
      .Ren         (Ren),
      .Rdir        (Rdir),
      .Serial_IO   (w_sio)
   );

   function automatic logic [31:0] mk_rep(input bit start, input int x, input int y);
      logic [31:0] r;
      r = '0;
      r[28] = start;
      r[15:8] = x[7:0];
      r[7:0] = y[7:0];
      return r;
   endfunction

   function automatic logic [3:0] model(input bit start, input int x, input int y, input bit flt);
      int l, r;
      bit le, re;
      l = y + x;
      r = y - x;
      le = (l > DZ) || (l < -DZ);
      re = (r > DZ) || (r < -DZ);
      if (start || flt) begin
         le = 0;
         re = 0;
      end
      return {le, le && (l >= 0), re, re && (r >= 0)};
   endfunction

   task automatic wait_level(input logic v, input int budget_ns, output bit ok);
      ok = 0;
      for (int i = 0; i < budget_ns / 10; i++) begin
         if (w_sio === v) begin
            ok = 1;
            break;
         end
         #10;
      end
   endtask

   task automatic answer(input logic [31:0] rep);
      #2000;
      for (int i = 31; i >= 0; i--) begin
         r_ctl_low = 1'b1;
         #(rep[i] ? 1000 : 3000);
         r_ctl_low = 1'b0;
         #(rep[i] ? 3000 : 1000);
      end
      r_ctl_low = 1'b1;
      #1000;
      r_ctl_low = 1'b0;
   endtask

   // Decodes the 8 command bits plus stop; optionally replies with rep.
   task automatic serve_poll(input logic [31:0] rep, input bit do_answer, output bit ok,
                             output logic [8:0] cmd, output time t_first, output time t_last);
      bit okb;
      cmd = '0;
      t_first = 0;
      t_last = 0;
      wait_level(1'b0, 400_000, ok);
      if (!ok) return;
      t_first = $time;
      for (int b = 0; b < 9; b++) begin
         if (b > 0) begin
            wait_level(1'b0, 10_000, okb);
            if (!okb) begin
               ok = 0;
               return;
            end
         end
         t_last = $time;
         #2000;
         cmd = {cmd[7:0], w_sio};
         wait_level(1'b1, 10_000, okb);
         if (!okb) begin
            ok = 0;
            return;
         end
      end
      if (do_answer) answer(rep);
   endtask

   task automatic test_reset;
      bit ok;
      logic [8:0] cmd;
      time t0, tf, tl;
      longint d;
      logic [3:0] exp;
      #1 Global_Reset = 1'b0;
      #50;
      n_vec++;
      if ({Len, Ldir, Ren, Rdir} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want 0000", {Len, Ldir, Ren, Rdir});
      end
      n_vec++;
      if (w_sio !== 1'b1) begin
         n_err++;
         $display("FAIL reset_line: got %b want released(1)", w_sio);
      end
      #50 Global_Reset = 1'b1;
      t0 = $time;
      q_exp.push_back(model(0, 0, 0, 0));
      serve_poll(mk_rep(0, 0, 0), 1, ok, cmd, tf, tl);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL first_poll: no command seen within budget");
      end
      d = longint'(tf) - longint'(t0);
      n_vec++;
      if (d < 19_900 || d > 20_100) begin
         n_err++;
         $display("FAIL first_poll_time: got %0d ns want 20000 +-100 ns", d);
      end
      n_vec++;
      if (cmd !== 9'b0_0000_0011) begin
         n_err++;
         $display("FAIL command_bits: got %b want 000000011", cmd);
      end
      #2000;
      @(negedge Clk);
      exp = q_exp.pop_front();
      n_vec++;
      if ({Len, Ldir, Ren, Rdir} !== exp) begin
         n_err++;
         $display("FAIL neutral_report: got %b want %b", {Len, Ldir, Ren, Rdir}, exp);
      end
   endtask

   task automatic test_joystick;
      int tx[7] = '{0, 100, 5, 0, 0, 0, -128};
      int ty[7] = '{100, 0, -5, 16, 17, -17, -128};
      bit ok;
      logic [8:0] cmd;
      time tf, tl;
      logic [3:0] exp;
      for (int i = 0; i < 7; i++) begin
         q_exp.push_back(model(0, tx[i], ty[i], 0));
         serve_poll(mk_rep(0, tx[i], ty[i]), 1, ok, cmd, tf, tl);
         n_vec++;
         if (!ok) begin
            n_err++;
            $display("FAIL joy_poll_%0d: no command seen within budget", i);
         end
         #2000;
         @(negedge Clk);
         exp = q_exp.pop_front();
         n_vec++;
         if ({Len, Ldir, Ren, Rdir} !== exp) begin
            n_err++;
            $display("FAIL joy_x%0d_y%0d: got %b want %b", tx[i], ty[i], {Len, Ldir, Ren, Rdir}, exp);
         end
      end
   endtask

   task automatic test_estop_float;
      bit st[3] = '{1, 0, 0};
      bit fl[3] = '{0, 1, 0};
      bit ok;
      logic [8:0] cmd;
      time tf, tl;
      logic [3:0] exp;
      for (int i = 0; i < 3; i++) begin
         Float = fl[i];
         q_exp.push_back(model(st[i], 0, 100, fl[i]));
         serve_poll(mk_rep(st[i], 0, 100), 1, ok, cmd, tf, tl);
         n_vec++;
         if (!ok) begin
            n_err++;
            $display("FAIL ef_poll_%0d: no command seen within budget", i);
         end
         #2000;
         @(negedge Clk);
         exp = q_exp.pop_front();
         n_vec++;
         if ({Len, Ldir, Ren, Rdir} !== exp) begin
            n_err++;
            $display("FAIL estop_float_%0d: got %b want %b", i, {Len, Ldir, Ren, Rdir}, exp);
         end
         if (fl[i]) begin
            Float = 1'b0;
            #1;
            q_exp.push_back(model(0, 0, 100, 0));
            exp = q_exp.pop_front();
            n_vec++;
            if ({Len, Ldir, Ren, Rdir} !== exp) begin
               n_err++;
               $display("FAIL float_release: got %b want %b", {Len, Ldir, Ren, Rdir}, exp);
            end
         end
      end
   endtask

   task automatic test_timeout;
      bit ok;
      logic [8:0] cmd;
      time tf, tl, t_stop;
      longint d;
      logic [3:0] exp;
      q_exp.push_back(model(0, 0, 100, 0));
      serve_poll(mk_rep(0, 0, 100), 1, ok, cmd, tf, tl);
      #2000;
      @(negedge Clk);
      exp = q_exp.pop_front();
      n_vec++;
      if (!ok || {Len, Ldir, Ren, Rdir} !== exp) begin
         n_err++;
         $display("FAIL to_good_poll: ok=%0d got %b want %b", ok, {Len, Ldir, Ren, Rdir}, exp);
      end
      serve_poll('0, 0, ok, cmd, tf, t_stop);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL to_silent_poll: no command seen within budget");
      end
      #(t_stop + 200_000 - $time);
      @(negedge Clk);
      n_vec++;
      if ({Len, Ldir, Ren, Rdir} !== exp) begin
         n_err++;
         $display("FAIL to_before_expiry: got %b want %b", {Len, Ldir, Ren, Rdir}, exp);
      end
      #2000;
      @(negedge Clk);
      n_vec++;
      if ({Len, Ldir, Ren, Rdir} !== 4'b0000) begin
         n_err++;
         $display("FAIL to_after_expiry: got %b want 0000", {Len, Ldir, Ren, Rdir});
      end
      q_exp.push_back(model(0, 0, 100, 0));
      serve_poll(mk_rep(0, 0, 100), 1, ok, cmd, tf, tl);
      d = longint'(tf) - longint'(t_stop);
      n_vec++;
      if (!ok || d < 220_800 || d > 221_200) begin
         n_err++;
         $display("FAIL to_next_poll_time: ok=%0d got %0d ns want 221000 +-200 ns", ok, d);
      end
      #2000;
      @(negedge Clk);
      exp = q_exp.pop_front();
      n_vec++;
      if ({Len, Ldir, Ren, Rdir} !== exp) begin
         n_err++;
         $display("FAIL to_recovered: got %b want %b", {Len, Ldir, Ren, Rdir}, exp);
      end
   endtask

   task automatic test_reset_mid_tx;
      bit ok;
      logic [8:0] cmd;
      time t0, tf, tl;
      longint d;
      logic [3:0] exp;
      wait_level(1'b0, 400_000, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL mid_tx_poll: no command seen within budget");
      end
      #5000;
      Global_Reset = 1'b0;
      #1;
      n_vec++;
      if (w_sio !== 1'b1) begin
         n_err++;
         $display("FAIL mid_tx_release: got %b want released(1)", w_sio);
      end
      n_vec++;
      if ({Len, Ldir, Ren, Rdir} !== 4'b0000) begin
         n_err++;
         $display("FAIL mid_tx_outputs: got %b want 0000", {Len, Ldir, Ren, Rdir});
      end
      #500;
      @(negedge Clk);
      Global_Reset = 1'b1;
      t0 = $time;
      q_exp.push_back(model(0, 0, 100, 0));
      serve_poll(mk_rep(0, 0, 100), 1, ok, cmd, tf, tl);
      d = longint'(tf) - longint'(t0);
      n_vec++;
      if (!ok || d < 19_900 || d > 20_100 || cmd !== 9'b0_0000_0011) begin
         n_err++;
         $display("FAIL restart_poll: ok=%0d t=%0d ns cmd=%b want 20000 ns cmd 000000011", ok, d, cmd);
      end
      #2000;
      @(negedge Clk);
      exp = q_exp.pop_front();
      n_vec++;
      if ({Len, Ldir, Ren, Rdir} !== exp) begin
         n_err++;
         $display("FAIL restart_drive: got %b want %b", {Len, Ldir, Ren, Rdir}, exp);
      end
   endtask

   initial begin
      #8_000_000;
      $display("FAIL watchdog: time budget expired, got stuck want summary");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_joystick();
      test_estop_float();
      test_timeout();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/n64_remote.md
Name: n64_remote

Overview:
- Top-level block for a wired N64-controller-driven two-motor vehicle.
- Periodically polls an N64 controller over its single-wire open-drain data line and decodes the 32-bit button/joystick report.
- Converts the joystick into differential-drive enable/direction signals for a left and a right H-bridge.
- Sits directly at the FPGA pins: controller data pin, the motor driver inputs, and a float/coast switch.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency; sets the cycles per microsecond (US_CYC = CLK_HZ/1_000_000 = 50).
- POLL_US, 10_000: interval between poll starts, in µs.
- TIMEOUT_US, 200: maximum wait for any expected falling edge from the controller.
- DEADZONE, 16: magnitude at or below which a mixed drive value counts as zero.

Ports:
- Clk  in  1  system clock; rising edge only.
- Global_Reset  in  1  asynchronous, active-low reset.
- Float  in  1  when 1, both motors coast (Len=Ren=0), regardless of controller data.
- Len  out  1  left motor enable.
- Ldir  out  1  left motor direction (1 = forward).
- Ren  out  1  right motor enable.
- Rdir  out  1  right motor direction (1 = forward).
- Serial_IO  inout  1  open-drain controller data line. The block only ever drives 0 or releases to Z; an external pull-up provides the high level.

Behaviour:
- Reset (Global_Reset=0):
  - Len, Ldir, Ren, Rdir = 0; Serial_IO = Z.
  - Poll timer = 0; FSM = IDLE; latched report = 0.
- Line input: Serial_IO passes through a 2-FF synchronizer before any use.
- Bit encoding on the wire (4 µs per bit):
  - '0' = 3 µs low, then 1 µs released.
  - '1' = 1 µs low, then 3 µs released.
- FSM states and transitions:
  - IDLE: count to POLL_US·US_CYC, then go to TX. The first poll starts POLL_US after reset release.
  - TX: send command 0x01 MSB-first (8 bits), then a stop bit (1 µs low, then release). After the stop, go to RX with Serial_IO = Z.
  - RX: 32 data bits.
    - For each bit, wait for a synchronized falling edge, then sample the line 2 µs after the edge. High = 1.
    - Shift in MSB-first.
    - After 32 bits, wait for the controller stop bit's falling edge (no sampling), then go to UPDATE.
  - UPDATE: latch the 32-bit report in one cycle, recompute outputs, return to IDLE.
  - Timeout: if no falling edge occurs within TIMEOUT_US in RX, abort, clear the latched report to 0 (motors off), and return to IDLE.
- Report layout (bit 31 first):
  - A, B, Z, Start, DUp, DDown, DLeft, DRight
  - two reserved bits, L, R
  - CUp, CDown, CLeft, CRight
  - X[7:0] (bits 15:8, signed)
  - Y[7:0] (bits 7:0, signed)
- Mixing:
  - 10-bit signed arithmetic, left = Y + X, right = Y − X; no overflow is possible at this width.
  - Per side: enable = |value| > DEADZONE; dir = (value ≥ 0).
  - When enable = 0, dir is forced to 0.
  - Start button pressed: both enables = 0 (e-stop), overriding the joystick.
- Float:
  - Float=1 forces Len=Ren=0 and Ldir=Rdir=0 combinationally from the registered values.
  - Polling continues while Float=1.
- Outputs are registered and change only in UPDATE or on timeout. The exception is the Float gating.
- Reset asserted mid-transfer: Serial_IO is released immediately (asynchronous) and all state clears.

Decomposition:
- Package n64_pkg holds:
  - POLL_CMD = 8'h01
  - bit-timing constants in µs (T_SHORT = 1, T_LONG = 3, T_BIT = 4, T_SAMPLE = 2)
  - report bit indices (BTN_START = 31-3, X_MSB = 15, Y_MSB = 7)
  - FSM state typedef
- One sub-module, n64_serial_phy, handles the wire side: TX bit shaping, RX edge detection and sampling, timeout. Its interface:
  - inputs: start, clock, reset
  - outputs: done, timeout, data[31:0]
  - tri-state drive of Serial_IO
- The top level holds the poll timer, mixing, and motor outputs.

Test Plan:
1. Reset held low 100 ns, then released (POLL_US = 20): all motor outputs 0 and Serial_IO Z during reset. The first low pulse appears 20 µs after release, and the command waveform reads bits 0000_0001 + stop (timing within ±1 cycle).
2. Controller model answers X=0, Y=+100, Start=0: after UPDATE, Len=Ren=1 and Ldir=Rdir=1.
3. Answer X=+100, Y=0: left = +100 gives Len=1, Ldir=1; right = −100 gives Ren=1, Rdir=0. Answer X=5, Y=−5 (inside DEADZONE): all outputs 0.
4. Answer Y=+100 with Start bit set: Len=Ren=0. Then Float=1 with a valid forward report: Len=Ren=Ldir=Rdir=0. Float=0 on the next poll restores forward drive.
5. After one good forward report, the model stays silent: after TIMEOUT_US, the outputs drop to 0 and the next poll starts POLL_US later.
6. Assert Global_Reset mid-TX: Serial_IO releases immediately and outputs are 0. After release, polling restarts cleanly from IDLE.
